// File: rtl/divider_8by4_seq_if.sv
// Handshake and operand/result bundle for the 8-by-4 sequential divider.
`timescale 1ns/1ps
interface divider_8by4_seq_if;
  logic       start_i;
  logic [7:0] dividend_i;
  logic [3:0] divisor_i;
  logic [7:0] quot_o;
  logic [3:0] rem_o;
  logic       busy_o;
  logic       done_o;
  logic       div_by_zero_o;
  logic       chk_err_o;

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output quot_o, rem_o, busy_o, done_o, div_by_zero_o, chk_err_o
  );

  modport master (
    output start_i, dividend_i, divisor_i,
    input  quot_o, rem_o, busy_o, done_o, div_by_zero_o, chk_err_o
  );
endinterface

// File: rtl/divider_8by4_seq.sv
// Restoring 8/4 unsigned divider, one quotient bit per clock.
// Optional result self-check enabled by DIVIDER_SELFCHECK_EN.
//   state | meaning
//   IDLE  | waiting for start; divide-by-zero answered here in one edge
//   RUN   | eight restoring iterations, MSB first
`timescale 1ns/1ps
module divider_8by4_seq (
  input  logic clk,
  input  logic rst_n,
  divider_8by4_seq_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [3:0] dvs_q, dvs_d;
  logic [4:0] r_q, r_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       done_q, done_d;
  logic       dbz_q, dbz_d;

  logic [4:0] p;
  logic [4:0] r_sub;
  logic       ge;
  logic       accept;

  assign p      = {r_q[3:0], d_q[7]};
  assign ge     = (p >= {1'b0, dvs_q});
  assign r_sub  = p - {1'b0, dvs_q};
  assign accept = (state_q == IDLE) && bus.start_i && (bus.divisor_i != 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= 8'h00;
      dvs_q   <= 4'h0;
      r_q     <= 5'h00;
      cnt_q   <= 3'h0;
      quot_q  <= 8'h00;
      rem_q   <= 4'h0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          d_d     = bus.dividend_i;
          dvs_d   = bus.divisor_i;
          r_d     = 5'h00;
          cnt_d   = 3'h0;
          dbz_d   = 1'b0;
          state_d = RUN;
        end else if (bus.start_i) begin
          quot_d = 8'hFF;
          rem_d  = 4'h0;
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      RUN: begin
        r_d   = ge ? r_sub : p;
        d_d   = {d_q[6:0], ge};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          quot_d  = {d_q[6:0], ge};
          rem_d   = ge ? r_sub[3:0] : p[3:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.quot_o        = quot_q;
  assign bus.rem_o         = rem_q;
  assign bus.busy_o        = (state_q == RUN);
  assign bus.done_o        = done_q;
  assign bus.div_by_zero_o = dbz_q;

`ifdef DIVIDER_SELFCHECK_EN
  // Reconstruct the dividend from the held result while done is high.
  logic [7:0]  dividend_q;
  logic        chk_q;
  logic [11:0] recon;

  assign recon = ({4'h0, quot_q} * {8'h00, dvs_q}) + {8'h00, rem_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q <= 8'h00;
      chk_q      <= 1'b0;
    end else begin
      if (accept)
        dividend_q <= bus.dividend_i;
      if (done_q && !dbz_q && (recon != {4'h0, dividend_q}))
        chk_q <= 1'b1;
    end
  end

  assign bus.chk_err_o = chk_q;
`else
  assign bus.chk_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_divider_8by4_seq.sv
// Directed bench for divider_8by4_seq: reset, boundaries, divide-by-zero, handshake, exhaustive sweep.
`timescale 1ns/1ps
module tb_divider_8by4_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  divider_8by4_seq_if bus ();
  divider_8by4_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Launch a division from the idle phase; k = edges after the accepting edge until done is seen.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int k);
    bus.start_i    = 1'b1;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    @(posedge clk); #1;
    bus.start_i    = 1'b0;
    bus.dividend_i = ~a;
    bus.divisor_i  = b ^ 4'h5;
    k = 0;
    while (!bus.done_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.dividend_i = 8'h00;
    bus.divisor_i  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.quot_o, bus.rem_o} !== 12'h000) begin
      n_bad++; $display("FAIL reset_result: got q=%0d r=%0d want 0 0", bus.quot_o, bus.rem_o);
    end
    n_cmp++;
    if ({bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.chk_err_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got busy/done/dbz/chk=%b%b%b%b want 0000",
                        bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.chk_err_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_boundaries();
    logic [7:0] va [4] = '{8'd255, 8'd255, 8'd0, 8'd14};
    logic [3:0] vb [4] = '{4'd1, 4'd15, 4'd9, 4'd15};
    logic [7:0] vq [4] = '{8'd255, 8'd17, 8'd0, 8'd0};
    logic [3:0] vr [4] = '{4'd0, 4'd0, 4'd0, 4'd14};
    int k;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], k);
      n_cmp++;
      if (k !== 8) begin
        n_bad++; $display("FAIL bnd_latency[%0d]: got %0d edges want 8", i, k);
      end
      n_cmp++;
      if ({bus.quot_o, bus.rem_o} !== {vq[i], vr[i]}) begin
        n_bad++; $display("FAIL bnd_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                          va[i], vb[i], bus.quot_o, bus.rem_o, vq[i], vr[i]);
      end
      n_cmp++;
      if ({bus.busy_o, bus.div_by_zero_o} !== 2'b00) begin
        n_bad++; $display("FAIL bnd_flags[%0d]: got busy=%b dbz=%b want 0 0", i, bus.busy_o, bus.div_by_zero_o);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.done_o, bus.quot_o, bus.rem_o} !== {1'b0, vq[i], vr[i]}) begin
        n_bad++; $display("FAIL bnd_hold[%0d]: got done=%b q=%0d r=%0d want done=0 q=%0d r=%0d",
                          i, bus.done_o, bus.quot_o, bus.rem_o, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int k;
    run_div(8'd77, 4'd0, k);
    n_cmp++;
    if (k !== 0) begin
      n_bad++; $display("FAIL dbz_latency: got %0d edges want 0 (done right after accept)", k);
    end
    n_cmp++;
    if ({bus.quot_o, bus.rem_o, bus.div_by_zero_o, bus.busy_o} !== {8'hFF, 4'h0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL dbz_result: got q=%h r=%0d dbz=%b busy=%b want q=ff r=0 dbz=1 busy=0",
                        bus.quot_o, bus.rem_o, bus.div_by_zero_o, bus.busy_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.done_o, bus.quot_o} !== {1'b0, 8'hFF}) begin
      n_bad++; $display("FAIL dbz_hold: got done=%b q=%h want done=0 q=ff", bus.done_o, bus.quot_o);
    end
    run_div(8'd77, 4'd7, k);
    n_cmp++;
    if (k !== 8) begin
      n_bad++; $display("FAIL dbz_next_latency: got %0d edges want 8", k);
    end
    n_cmp++;
    if ({bus.quot_o, bus.rem_o, bus.div_by_zero_o} !== {8'd11, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL dbz_next_result: got q=%0d r=%0d dbz=%b want q=11 r=0 dbz=0",
                        bus.quot_o, bus.rem_o, bus.div_by_zero_o);
    end
  endtask

  task automatic test_reset_mid_run();
    int k;
    int seen_done = 0;
    bus.start_i    = 1'b1;
    bus.dividend_i = 8'd200;
    bus.divisor_i  = 4'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (bus.done_o) seen_done++;
    end
    n_cmp++;
    if (bus.busy_o !== 1'b1) begin
      n_bad++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.quot_o, bus.rem_o, bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.chk_err_o} !== 16'h0000) begin
      n_bad++; $display("FAIL midrst_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b chk=%b want all 0",
                        bus.quot_o, bus.rem_o, bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.chk_err_o);
    end
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) seen_done++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++; $display("FAIL midrst_no_done: got %0d done/busy cycles want 0", seen_done);
    end
    run_div(8'd200, 4'd7, k);
    n_cmp++;
    if (k !== 8) begin
      n_bad++; $display("FAIL midrst_latency: got %0d edges want 8", k);
    end
    n_cmp++;
    if ({bus.quot_o, bus.rem_o} !== {8'd28, 4'd4}) begin
      n_bad++; $display("FAIL midrst_result: got q=%0d r=%0d want q=28 r=4", bus.quot_o, bus.rem_o);
    end
  endtask

  task automatic test_handshake();
    int n_done = 0;
    int k;
    bus.start_i    = 1'b1;
    bus.dividend_i = 8'd100;
    bus.divisor_i  = 4'd3;
    @(posedge clk); #1;
    for (int e = 1; e <= 8; e++) begin
      bus.start_i    = (e == 2) || (e == 5);
      bus.dividend_i = 8'd9;
      bus.divisor_i  = (e == 5) ? 4'd0 : 4'd2;
      @(posedge clk); #1;
      if (bus.done_o) n_done++;
    end
    bus.start_i = 1'b0;
    n_cmp++;
    if (n_done !== 1 || bus.done_o !== 1'b1) begin
      n_bad++; $display("FAIL hs_single_done: got %0d dones (done now=%b) want 1 at E8", n_done, bus.done_o);
    end
    n_cmp++;
    if ({bus.quot_o, bus.rem_o, bus.busy_o, bus.div_by_zero_o} !== {8'd33, 4'd1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL hs_result: got q=%0d r=%0d busy=%b dbz=%b want q=33 r=1 busy=0 dbz=0",
                        bus.quot_o, bus.rem_o, bus.busy_o, bus.div_by_zero_o);
    end
    bus.start_i    = 1'b1;
    bus.dividend_i = 8'd50;
    bus.divisor_i  = 4'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n_cmp++;
    if ({bus.busy_o, bus.done_o} !== 2'b10) begin
      n_bad++; $display("FAIL hs_accept_in_done: got busy=%b done=%b want busy=1 done=0", bus.busy_o, bus.done_o);
    end
    k = 0;
    while (!bus.done_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (k !== 8 || {bus.quot_o, bus.rem_o} !== {8'd10, 4'd0}) begin
      n_bad++; $display("FAIL hs_second: got %0d edges q=%0d r=%0d want 8 edges q=10 r=0", k, bus.quot_o, bus.rem_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eq;
    logic [3:0] er;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        bus.start_i    = 1'b1;
        bus.dividend_i = 8'(a);
        bus.divisor_i  = 4'(b);
        @(posedge clk); #1;
        bus.start_i    = 1'b0;
        bus.dividend_i = 8'($urandom);
        bus.divisor_i  = 4'($urandom);
        repeat (8) @(posedge clk);
        #1;
        eq = 8'(a / b);
        er = 4'(a % b);
        n_cmp++;
        if ({bus.done_o, bus.quot_o, bus.rem_o, bus.div_by_zero_o} !== {1'b1, eq, er, 1'b0}) begin
          n_bad++; $display("FAIL b2b %0d/%0d: got done=%b q=%0d r=%0d dbz=%b want done=1 q=%0d r=%0d dbz=0",
                            a, b, bus.done_o, bus.quot_o, bus.rem_o, bus.div_by_zero_o, eq, er);
        end
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.chk_err_o, bus.busy_o, bus.done_o} !== 3'b000) begin
      n_bad++; $display("FAIL b2b_end: got chk=%b busy=%b done=%b want 0 0 0", bus.chk_err_o, bus.busy_o, bus.done_o);
    end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_div_by_zero();
    test_reset_mid_run();
    test_handshake();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
